spi_master_cfg: RTL and testbench

SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

---
 rtl/spi_master_cfg.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_master_cfg.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: single-word SPI master with compile-time mode selection.
//
// Parameters
//   DATA_WIDTH : bits per transfer (2..32)
//   CLK_DIV    : clk cycles per spi_clk half-period (>= 2)
//   CPOL       : spi_clk idle level
//   CPHA       : 0 = sample on leading edge, 1 = sample on trailing edge
//   LSB_FIRST  : 1 = bit 0 shifted first, 0 = MSB shifted first
//   CS_GAP     : clk cycles spent in GAP (spi_cs_n high, busy) after a transfer
//
// Ports
//   clk, rst_n          : system clock, synchronous active-low reset
//   tx_data, tx_valid   : request word / request strobe
//   tx_ready            : high in IDLE only
//   rx_data, rx_valid   : last received word, one-cycle update pulse
//   busy                : high outside IDLE
//   spi_clk, spi_mosi,
//   spi_miso, spi_cs_n  : SPI bus (all outputs registered)
//
// Handshake: a request is accepted on a rising clk edge where tx_valid and
// tx_ready are both high; tx_data is captured on that edge only. tx_valid
// while tx_ready is low is dropped, never queued.

module spi_master_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 1350,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int LSB_FIRST  = 1,
  parameter int CS_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic                  spi_cs_n
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
  localparam int GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);
  localparam logic              CPOL_BIT  = (CPOL != 0);
  localparam logic              CPHA_BIT  = (CPHA != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;     // spi_clk edges already produced
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;   // bits still to be driven
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;

  logic                  tick;
  logic [EDGE_W-1:0]     edge_num;
  logic                  sample_edge;
  logic [DATA_WIDTH-1:0] rx_shifted;

  // Bit that goes out next, and the word left after it has gone.
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] drop_head(input logic [DATA_WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  assign tick     = (div_q == DIV_LAST);
  assign edge_num = edge_q + EDGE_W'(1);
  // Odd edges are leading edges; CPHA picks which edge parity samples MISO.
  // The other parity is the one that advances MOSI.
  assign sample_edge = edge_num[0] ^ CPHA_BIT;
  // First received bit must end in the position it was sent from.
  assign rx_shifted  = (LSB_FIRST != 0) ? {spi_miso, rx_sh_q[DATA_WIDTH-1:1]}
                                        : {rx_sh_q[DATA_WIDTH-2:0], spi_miso};

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    edge_d     = edge_q;
    gap_d      = gap_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;

    unique case (state_q)
      S_IDLE: begin
        div_d  = '0;
        edge_d = '0;
        gap_d  = '0;
        sclk_d = CPOL_BIT;
        mosi_d = 1'b0;
        cs_n_d = 1'b1;
        if (tx_valid) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
          if (!CPHA_BIT) begin
            // CPHA=0 needs the first bit on the wire before the first edge.
            mosi_d  = head_bit(tx_data);
            tx_sh_d = drop_head(tx_data);
          end else begin
            tx_sh_d = tx_data;
          end
        end
      end

      // SETUP is the first half-period; edge handling is shared with SHIFT
      // because edge 1 is simply edge_q==0 -> edge_num==1.
      S_SETUP, S_SHIFT: begin
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_num;
          if (sample_edge) begin
            rx_sh_d = rx_shifted;
          end
          if (edge_num == LAST_EDGE) begin
            state_d = S_HOLD;
            mosi_d  = 1'b0;
          end else begin
            state_d = S_SHIFT;
            if (!sample_edge) begin
              mosi_d  = head_bit(tx_sh_q);
              tx_sh_d = drop_head(tx_sh_q);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_HOLD: begin
        if (tick) begin
          div_d      = '0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          cs_n_d     = 1'b1;
          gap_d      = '0;
          state_d    = (CS_GAP == 0) ? S_IDLE : S_GAP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      edge_q     <= '0;
      gap_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= CPOL_BIT;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      gap_q      <= gap_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign tx_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg. Four instances cover the mode combinations; the
// expected bus waveform of each transfer is derived cycle by cycle from the
// timing rules (edge k at k*CLK_DIV cycles after acceptance) and the bit
// order, and received words go through an expected queue.

module tb_spi_master_cfg;

  localparam int W0 = 8,  D0 = 4, POL0 = 0, PHA0 = 0, LSB0 = 1, GAP0 = 2;
  localparam int W1 = 8,  D1 = 4, POL1 = 1, PHA1 = 1, LSB1 = 0, GAP1 = 2;
  localparam int W2 = 16, D2 = 3, POL2 = 0, PHA2 = 1, LSB2 = 1, GAP2 = 2;
  localparam int W3 = 5,  D3 = 2, POL3 = 1, PHA3 = 0, LSB3 = 0, GAP3 = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- per-instance signals ----------------
  logic [31:0] tx_data_s [4];
  logic [3:0]  tx_valid_s;
  logic [3:0]  tx_ready_s, rx_valid_s, busy_s, spi_clk_s, spi_mosi_s, spi_cs_n_s;
  logic [3:0]  spi_miso_s, miso_drv, loop_en;
  logic [31:0] rx_data_s [4];
  logic [7:0]  rx0, rx1;
  logic [15:0] rx2;
  logic [4:0]  rx3;

  assign rx_data_s[0] = 32'(rx0);
  assign rx_data_s[1] = 32'(rx1);
  assign rx_data_s[2] = 32'(rx2);
  assign rx_data_s[3] = 32'(rx3);
  assign spi_miso_s   = (loop_en & spi_mosi_s) | (~loop_en & miso_drv);

  spi_master_cfg #(.DATA_WIDTH(W0), .CLK_DIV(D0), .CPOL(POL0), .CPHA(PHA0),
                   .LSB_FIRST(LSB0), .CS_GAP(GAP0)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_s[0][W0-1:0]), .tx_valid(tx_valid_s[0]),
    .tx_ready(tx_ready_s[0]), .rx_data(rx0), .rx_valid(rx_valid_s[0]), .busy(busy_s[0]),
    .spi_clk(spi_clk_s[0]), .spi_mosi(spi_mosi_s[0]), .spi_miso(spi_miso_s[0]),
    .spi_cs_n(spi_cs_n_s[0]));

  spi_master_cfg #(.DATA_WIDTH(W1), .CLK_DIV(D1), .CPOL(POL1), .CPHA(PHA1),
                   .LSB_FIRST(LSB1), .CS_GAP(GAP1)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_s[1][W1-1:0]), .tx_valid(tx_valid_s[1]),
    .tx_ready(tx_ready_s[1]), .rx_data(rx1), .rx_valid(rx_valid_s[1]), .busy(busy_s[1]),
    .spi_clk(spi_clk_s[1]), .spi_mosi(spi_mosi_s[1]), .spi_miso(spi_miso_s[1]),
    .spi_cs_n(spi_cs_n_s[1]));

  spi_master_cfg #(.DATA_WIDTH(W2), .CLK_DIV(D2), .CPOL(POL2), .CPHA(PHA2),
                   .LSB_FIRST(LSB2), .CS_GAP(GAP2)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_s[2][W2-1:0]), .tx_valid(tx_valid_s[2]),
    .tx_ready(tx_ready_s[2]), .rx_data(rx2), .rx_valid(rx_valid_s[2]), .busy(busy_s[2]),
    .spi_clk(spi_clk_s[2]), .spi_mosi(spi_mosi_s[2]), .spi_miso(spi_miso_s[2]),
    .spi_cs_n(spi_cs_n_s[2]));

  spi_master_cfg #(.DATA_WIDTH(W3), .CLK_DIV(D3), .CPOL(POL3), .CPHA(PHA3),
                   .LSB_FIRST(LSB3), .CS_GAP(GAP3)) u3 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_s[3][W3-1:0]), .tx_valid(tx_valid_s[3]),
    .tx_ready(tx_ready_s[3]), .rx_data(rx3), .rx_valid(rx_valid_s[3]), .busy(busy_s[3]),
    .spi_clk(spi_clk_s[3]), .spi_mosi(spi_mosi_s[3]), .spi_miso(spi_miso_s[3]),
    .spi_cs_n(spi_cs_n_s[3]));

  // ---------------- configuration lookup ----------------
  function automatic int cw(input int s);
    case (s) 0: return W0; 1: return W1; 2: return W2; default: return W3; endcase
  endfunction
  function automatic int cdiv(input int s);
    case (s) 0: return D0; 1: return D1; 2: return D2; default: return D3; endcase
  endfunction
  function automatic int cpol(input int s);
    case (s) 0: return POL0; 1: return POL1; 2: return POL2; default: return POL3; endcase
  endfunction
  function automatic int cpha(input int s);
    case (s) 0: return PHA0; 1: return PHA1; 2: return PHA2; default: return PHA3; endcase
  endfunction
  function automatic int clsb(input int s);
    case (s) 0: return LSB0; 1: return LSB1; 2: return LSB2; default: return LSB3; endcase
  endfunction
  function automatic int cgap(input int s);
    case (s) 0: return GAP0; 1: return GAP1; 2: return GAP2; default: return GAP3; endcase
  endfunction

  function automatic logic [31:0] wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  // n-th bit on the wire (n = 0 is the first bit sent).
  function automatic logic wire_bit(input int s, input logic [31:0] word, input int n);
    return (clsb(s) != 0) ? word[n] : word[cw(s) - 1 - n];
  endfunction

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rx [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic chk_idle(input int s, input string tag);
    chk({tag, "_cs_n"},     32'(spi_cs_n_s[s]), 32'd1);
    chk({tag, "_spi_clk"},  32'(spi_clk_s[s]),  32'(cpol(s)));
    chk({tag, "_mosi"},     32'(spi_mosi_s[s]), 32'd0);
    chk({tag, "_busy"},     32'(busy_s[s]),     32'd0);
    chk({tag, "_tx_ready"}, 32'(tx_ready_s[s]), 32'd1);
    chk({tag, "_rx_valid"}, 32'(rx_valid_s[s]), 32'd0);
    chk({tag, "_rx_data"},  rx_data_s[s],       exp_rx[s]);
  endtask

  // ---------------- driver: one full transfer ----------------
  // Called just after a falling edge. Presents word, then follows the
  // transfer to the first IDLE cycle, checking every cycle. With hold=1,
  // tx_valid stays high throughout (next call chains back-to-back).
  task automatic run_xfer(input int s, input logic [31:0] word, input logic [31:0] mword,
                          input bit loop, input bit hold,
                          output int low_cnt, output int gap_cnt);
    int w, d, t_rx, t_end, e, n;
    bit in_xfer;
    logic exp_mosi, exp_clk;
    logic [31:0] m, sent;
    w = cw(s); d = cdiv(s); m = wmask(w);
    sent  = word & m;
    t_rx  = (2 * w + 1) * d + 1;           // cycle of the rx_valid pulse
    t_end = t_rx + cgap(s);                // first IDLE cycle afterwards
    exp_q.push_back(loop ? sent : (mword & m));
    chk("ready_pre", 32'(tx_ready_s[s]), 32'd1);
    loop_en[s]    = loop;
    tx_data_s[s]  = word;
    tx_valid_s[s] = 1'b1;
    low_cnt = 0;
    gap_cnt = 0;
    for (int t = 1; t <= t_end; t++) begin
      @(negedge clk);
      in_xfer = (t < t_rx);
      e = in_xfer ? (t - 1) / d : 2 * w;   // edges seen so far
      exp_clk = in_xfer ? logic'((cpol(s) + e) % 2) : logic'(cpol(s));
      if (!in_xfer || e >= 2 * w)      exp_mosi = 1'b0;
      else if (cpha(s) == 0)           exp_mosi = wire_bit(s, sent, e / 2);
      else if (e == 0)                 exp_mosi = 1'b0;
      else                             exp_mosi = wire_bit(s, sent, (e - 1) / 2);
      chk("cs_n",     32'(spi_cs_n_s[s]), 32'(!in_xfer));
      chk("spi_clk",  32'(spi_clk_s[s]),  32'(exp_clk));
      chk("mosi",     32'(spi_mosi_s[s]), 32'(exp_mosi));
      chk("busy",     32'(busy_s[s]),     32'(t < t_end));
      chk("tx_ready", 32'(tx_ready_s[s]), 32'(t >= t_end));
      chk("rx_valid", 32'(rx_valid_s[s]), 32'(t == t_rx));
      if (t == t_rx) begin
        if (exp_q.size() > 0) exp_rx[s] = exp_q.pop_front();
      end
      chk("rx_data", rx_data_s[s], exp_rx[s]);
      if (!spi_cs_n_s[s]) low_cnt++;
      if (spi_cs_n_s[s] && busy_s[s]) gap_cnt++;
      // MISO bit n must be stable over its sampling edge.
      if (in_xfer) begin
        n = (cpha(s) == 0) ? e / 2 : (e - 1) / 2;
        if (n >= 0 && n < w) miso_drv[s] = wire_bit(s, mword & m, n);
      end
      if (t < t_end) begin
        tx_valid_s[s] = hold ? 1'b1 : 1'($urandom_range(0, 1));
        tx_data_s[s]  = $urandom;
      end else begin
        tx_valid_s[s] = hold;
      end
    end
  endtask

  // Reset pulse landing on edge 7 of a transfer.
  task automatic abort_xfer(input int s, input logic [31:0] word);
    int d, w;
    d = cdiv(s); w = cw(s);
    loop_en[s]    = 1'b1;
    tx_data_s[s]  = word;
    tx_valid_s[s] = 1'b1;
    for (int t = 1; t <= 7 * d; t++) begin
      @(negedge clk);
      tx_valid_s[s] = 1'($urandom_range(0, 1));
      if (t == 7 * d) begin
        chk("abort_pre_cs_n", 32'(spi_cs_n_s[s]), 32'd0);
        rst_n = 1'b0;
      end
    end
    tx_valid_s[s] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) exp_rx[k] = '0;
    chk_idle(s, "abort_post");
    for (int t = 0; t < (2 * w + 2) * d; t++) begin
      @(negedge clk);
      chk("abort_no_rx_valid", 32'(rx_valid_s[s]), 32'd0);
    end
    chk("abort_rx_data", rx_data_s[s], 32'd0);
    chk("abort_busy", 32'(busy_s[s]), 32'd0);
  endtask

  // tx_valid and reset on the same edge: reset wins.
  task automatic reset_vs_valid(input int s);
    rst_n = 1'b0;
    tx_data_s[s]  = $urandom;
    tx_valid_s[s] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tx_valid_s[s] = 1'b0;
    chk("rv_busy", 32'(busy_s[s]), 32'd0);
    chk("rv_tx_ready", 32'(tx_ready_s[s]), 32'd1);
    chk("rv_cs_n", 32'(spi_cs_n_s[s]), 32'd1);
    @(negedge clk);
    chk("rv_busy_after", 32'(busy_s[s]), 32'd0);
    chk("rv_tx_ready_after", 32'(tx_ready_s[s]), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int low_cnt, gap_cnt, s;
    for (int k = 0; k < 4; k++) begin
      tx_data_s[k] = '0;
      exp_rx[k]    = '0;
    end
    tx_valid_s = '0;
    miso_drv   = '0;
    loop_en    = '0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) chk_idle(k, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0, LSB first, loopback of 0xA5.
    run_xfer(0, 32'hA5, 32'h0, 1'b1, 1'b0, low_cnt, gap_cnt);
    chk("a5_rx_data", rx_data_s[0], 32'hA5);
    chk("a5_cs_low_cycles", 32'(low_cnt), 32'd68);
    chk("a5_gap_cycles", 32'(gap_cnt), 32'(GAP0));

    // CPOL=1 CPHA=1 MSB first, tx 0x3C, MISO carries 0xC3.
    run_xfer(1, 32'h3C, 32'hC3, 1'b0, 1'b0, low_cnt, gap_cnt);
    chk("c3_rx_data", rx_data_s[1], 32'hC3);

    // 16-bit back-to-back with tx_valid held high.
    run_xfer(2, 32'h1234, 32'h0, 1'b1, 1'b1, low_cnt, gap_cnt);
    chk("b2b_gap_cycles", 32'(gap_cnt), 32'(GAP2));
    run_xfer(2, 32'hBEEF, 32'h0, 1'b1, 1'b0, low_cnt, gap_cnt);
    chk("b2b_second_rx", rx_data_s[2], 32'hBEEF);

    // CS_GAP=0 instance, chained twice.
    run_xfer(3, $urandom, $urandom, 1'b0, 1'b1, low_cnt, gap_cnt);
    chk("nogap_gap_cycles", 32'(gap_cnt), 32'd0);
    run_xfer(3, $urandom, $urandom, 1'b0, 1'b0, low_cnt, gap_cnt);

    // Randomized transfers across all instances.
    for (int i = 0; i < 12; i++) begin
      s = $urandom_range(0, 3);
      run_xfer(s, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, low_cnt, gap_cnt);
      chk("rand_cs_low_cycles", 32'(low_cnt), 32'((2 * cw(s) + 1) * cdiv(s)));
    end

    abort_xfer(0, 32'h5A);
    abort_xfer(1, $urandom);
    reset_vs_valid(0);
    reset_vs_valid(2);

    // Normal operation after the resets.
    run_xfer(1, $urandom, $urandom, 1'b0, 1'b0, low_cnt, gap_cnt);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
